mips_ls_unit: RTL and testbench

//  Parametrised, handshaked load/store execution unit for MIPS I-type memory ops.

---
 rtl/mips_ls_pkg.sv | 48 ++++
 rtl/mips_ls_if.sv | 28 ++
 rtl/mips_ls_lane.sv | 48 ++++
 rtl/mips_ls_unit.sv | 164 ++++++++++++++++
 tb/tb_mips_ls_unit.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ls_pkg.sv
// Shared types for the MIPS load/store unit: opcodes, FSM states, access sizes
// and the opcode decoder used at instruction accept.
package mips_ls_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_MEM, ST_WB} state_t;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    typedef struct packed {
        logic  legal;
        logic  is_load;
        size_t size;
        logic  sign;
    } op_info_t;

    // Sub-word opcodes become illegal when the sub-word feature is off.
    function automatic op_info_t decode_op(input logic [5:0] opcode, input logic subword_en);
        op_info_t info;
        logic     sub;
        info = '{legal: 1'b1, is_load: 1'b0, size: SZ_W, sign: 1'b0};
        sub  = 1'b1;
        case (opcode)
            OP_LW:   begin info.is_load = 1'b1; info.sign = 1'b1; sub = 1'b0; end
            OP_SW:   sub = 1'b0;
            OP_LB:   begin info.is_load = 1'b1; info.size = SZ_B; info.sign = 1'b1; end
            OP_LBU:  begin info.is_load = 1'b1; info.size = SZ_B; end
            OP_LH:   begin info.is_load = 1'b1; info.size = SZ_H; info.sign = 1'b1; end
            OP_LHU:  begin info.is_load = 1'b1; info.size = SZ_H; end
            OP_SB:   info.size = SZ_B;
            OP_SH:   info.size = SZ_H;
            default: info.legal = 1'b0;
        endcase
        if (sub && !subword_en) begin
            info.legal = 1'b0;
        end
        return info;
    endfunction

endpackage

// File: rtl/mips_ls_if.sv
// Instruction handshake, retire status and debug GPR read port of the load/store unit.
interface mips_ls_if #(parameter int DATA_W = 32);

    logic              op_valid;
    logic              op_ready;
    logic [5:0]        opcode;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [15:0]       imm;
    logic              done;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] ea;
    logic              exc_align;
    logic              exc_illegal;
    logic [4:0]        dbg_ridx;
    logic [DATA_W-1:0] dbg_rdata;

    modport master (
        output op_valid, opcode, rs, rt, imm, dbg_ridx,
        input  op_ready, done, ld_data, ea, exc_align, exc_illegal, dbg_rdata
    );

    modport slave (
        input  op_valid, opcode, rs, rt, imm, dbg_ridx,
        output op_ready, done, ld_data, ea, exc_align, exc_illegal, dbg_rdata
    );

endinterface

// File: rtl/mips_ls_lane.sv
// Byte-lane datapath: extracts and extends load data, and merges store data into
// the addressed little-endian byte lanes of a memory word.
module mips_ls_lane
    import mips_ls_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]            word,
    input  logic [$clog2(DATA_W/8)-1:0]  off,
    input  size_t                        size,
    input  logic                         sign,
    input  logic [DATA_W-1:0]            st_src,
    output logic [DATA_W-1:0]            ld_val,
    output logic [DATA_W-1:0]            st_word
);

    localparam int L = $clog2(DATA_W/8);

    logic [L+2:0]      sh;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;

    assign sh      = {off, 3'b000};
    assign shifted = word >> sh;

    always_comb begin
        ld_val = '0;
        mask   = '0;
        case (size)
            SZ_B: begin
                ld_val = sign ? DATA_W'($signed(shifted[7:0])) : DATA_W'(shifted[7:0]);
                mask   = DATA_W'(8'hFF);
            end
            SZ_H: begin
                ld_val = sign ? DATA_W'($signed(shifted[15:0])) : DATA_W'(shifted[15:0]);
                mask   = DATA_W'(16'hFFFF);
            end
            default: begin
                ld_val = sign ? DATA_W'($signed(shifted[31:0])) : DATA_W'(shifted[31:0]);
                mask   = DATA_W'(32'hFFFF_FFFF);
            end
        endcase
    end

    // Only the lanes covered by the shifted mask take store data.
    assign st_word = (word & ~(mask << sh)) | ((st_src << sh) & (mask << sh));

endmodule

// File: rtl/mips_ls_unit.sv
// Multi-cycle MIPS load/store unit with internal GPR file and data memory.
// Sub-word loads/stores are enabled by defining MIPS_LS_SUBWORD_EN.
module mips_ls_unit
    import mips_ls_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 5,
    parameter int NREG   = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    mips_ls_if.slave bus
);

    localparam int L     = $clog2(DATA_W/8);
    localparam int DEPTH = 2**MEM_AW;
`ifdef MIPS_LS_SUBWORD_EN
    localparam logic SUBWORD_EN = 1'b1;
`else
    localparam logic SUBWORD_EN = 1'b0;
`endif

    state_t            state;
    op_info_t          info_q;
    logic [4:0]        rs_q;
    logic [4:0]        rt_q;
    logic [15:0]       imm_q;
    logic [DATA_W-1:0] st_src_q;
    logic [DATA_W-1:0] ea_q;
    logic [DATA_W-1:0] ld_data_q;
    logic              ready_q;
    logic              done_q;
    logic              exc_align_q;
    logic              exc_illegal_q;

    logic [DATA_W-1:0] gpr [NREG];
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DATA_W-1:0] ea_calc;
    logic              misalign;
    logic [MEM_AW-1:0] widx;
    logic [DATA_W-1:0] mem_rd;
    logic [DATA_W-1:0] lane_ld;
    logic [DATA_W-1:0] lane_st;

    function automatic logic [DATA_W-1:0] rd_gpr(input logic [4:0] idx);
        if (idx == 5'd0 || int'(idx) >= NREG) begin
            return '0;
        end
        return gpr[idx];
    endfunction

    assign ea_calc = rd_gpr(rs_q) + DATA_W'($signed(imm_q));
    assign widx    = ea_q[MEM_AW+L-1:L];
    assign mem_rd  = mem[widx];

    // A "word" is always the 32-bit lane, so its alignment is on ea[1:0] for any DATA_W.
    always_comb begin
        misalign = 1'b0;
        case (info_q.size)
            SZ_H:    misalign = ea_calc[0];
            SZ_W:    misalign = |ea_calc[1:0];
            default: misalign = 1'b0;
        endcase
    end

    mips_ls_lane #(.DATA_W(DATA_W)) u_lane (
        .word    (mem_rd),
        .off     (ea_q[L-1:0]),
        .size    (info_q.size),
        .sign    (info_q.sign),
        .st_src  (st_src_q),
        .ld_val  (lane_ld),
        .st_word (lane_st)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            info_q        <= '0;
            rs_q          <= '0;
            rt_q          <= '0;
            imm_q         <= '0;
            st_src_q      <= '0;
            ea_q          <= '0;
            ld_data_q     <= '0;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            exc_align_q   <= 1'b0;
            exc_illegal_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.op_valid) begin
                        info_q  <= decode_op(bus.opcode, SUBWORD_EN);
                        rs_q    <= bus.rs;
                        rt_q    <= bus.rt;
                        imm_q   <= bus.imm;
                        ready_q <= 1'b0;
                        state   <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    ea_q     <= ea_calc;
                    st_src_q <= rd_gpr(rt_q);
                    if (!info_q.legal) begin
                        exc_illegal_q <= 1'b1;
                        done_q        <= 1'b1;
                        state         <= ST_WB;
                    end else if (misalign) begin
                        exc_align_q <= 1'b1;
                        done_q      <= 1'b1;
                        state       <= ST_WB;
                    end else begin
                        state <= ST_MEM;
                    end
                end
                ST_MEM: begin
                    ld_data_q <= (info_q.is_load && rt_q != 5'd0) ? lane_ld : '0;
                    done_q    <= 1'b1;
                    state     <= ST_WB;
                end
                default: begin
                    ld_data_q     <= '0;
                    done_q        <= 1'b0;
                    exc_align_q   <= 1'b0;
                    exc_illegal_q <= 1'b0;
                    ready_q       <= 1'b1;
                    state         <= ST_IDLE;
                end
            endcase
        end
    end

    // Load results land in the GPR file on the MEM->WB edge, together with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                gpr[i] <= DATA_W'(i);
            end
        end else if (state == ST_MEM && info_q.is_load && rt_q != 5'd0 && int'(rt_q) < NREG) begin
            gpr[rt_q] <= lane_ld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= DATA_W'(i);
            end
        end else if (state == ST_MEM && !info_q.is_load) begin
            mem[widx] <= lane_st;
        end
    end

    assign bus.op_ready    = ready_q;
    assign bus.done        = done_q;
    assign bus.ld_data     = ld_data_q;
    assign bus.ea          = ea_q;
    assign bus.exc_align   = exc_align_q;
    assign bus.exc_illegal = exc_illegal_q;
    assign bus.dbg_rdata   = rd_gpr(bus.dbg_ridx);

endmodule

// File: tb/tb_mips_ls_unit.sv
// Directed plus randomized checks of mips_ls_unit (DATA_W=32) against a byte-level
// reference model of the GPR file and data memory.
module tb_mips_ls_unit;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

`ifdef MIPS_LS_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic [31:0] gpr_m [32];
    logic [31:0] mem_m [32];
    logic [5:0]  ops [9] = '{6'b100011, 6'b101011, 6'b100000, 6'b100100, 6'b100001,
                             6'b100101, 6'b101000, 6'b101001, 6'b001000};

    mips_ls_if #(.DATA_W(32)) bus ();

    mips_ls_unit #(.DATA_W(32), .MEM_AW(5), .NREG(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            gpr_m[i] = 32'(i);
            mem_m[i] = 32'(i);
        end
    endtask

    // Byte-addressed semantics: EA, size/alignment rules, little-endian byte moves.
    task automatic model_op(input logic [5:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [15:0] imm, output logic [31:0] x_ea, output logic [31:0] x_ld,
                            output logic x_al, output logic x_il, output int x_lat);
        int          size;
        int          widx;
        int          off;
        bit          is_load;
        bit          is_signed;
        bit          known;
        logic [31:0] v;
        logic [31:0] src;
        size = 4; is_load = 0; is_signed = 0; known = 1;
        case (opc)
            6'b100011: begin size = 4; is_load = 1; is_signed = 1; end
            6'b101011: size = 4;
            6'b100000: begin size = 1; is_load = 1; is_signed = 1; end
            6'b100100: begin size = 1; is_load = 1; end
            6'b100001: begin size = 2; is_load = 1; is_signed = 1; end
            6'b100101: begin size = 2; is_load = 1; end
            6'b101000: size = 1;
            6'b101001: size = 2;
            default:   known = 0;
        endcase
        x_ea  = (rs == 0 ? 32'd0 : gpr_m[rs]) + {{16{imm[15]}}, imm};
        x_ld  = 0;
        x_al  = 0;
        x_il  = 0;
        x_lat = 2;
        if (!known || (size != 4 && !SUBWORD)) begin
            x_il = 1;
        end else if ((x_ea & 32'(size - 1)) != 0) begin
            x_al = 1;
        end else begin
            x_lat = 3;
            widx  = int'(x_ea[6:2]);
            off   = int'(x_ea[1:0]);
            if (is_load) begin
                v = 0;
                for (int k = 0; k < size; k++) begin
                    v = v | (((mem_m[widx] >> (8 * (off + k))) & 32'hFF) << (8 * k));
                end
                if (is_signed && size < 4 && v[8 * size - 1]) begin
                    v = v | (32'hFFFF_FFFF << (8 * size));
                end
                if (rt != 0) begin
                    gpr_m[rt] = v;
                    x_ld      = v;
                end
            end else begin
                src = (rt == 0) ? 32'd0 : gpr_m[rt];
                for (int k = 0; k < size; k++) begin
                    mem_m[widx][8 * (off + k) +: 8] = src[8 * k +: 8];
                end
            end
        end
    endtask

    task automatic apply_stimulus(input logic [5:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                                  input logic [15:0] imm, input string tag);
        logic [31:0] x_ea;
        logic [31:0] x_ld;
        logic        x_al;
        logic        x_il;
        int          x_lat;
        int          lat;
        int          waited;
        logic [31:0] o_ea;
        logic [31:0] o_ld;
        logic        o_al;
        logic        o_il;
        waited = 0;
        while (!bus.op_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check_output({tag, ".ready"}, 32'(bus.op_ready), 32'd1);
        if (!bus.op_ready) return;
        model_op(opc, rs, rt, imm, x_ea, x_ld, x_al, x_il, x_lat);
        bus.opcode   = opc;
        bus.rs       = rs;
        bus.rt       = rt;
        bus.imm      = imm;
        bus.op_valid = 1'b1;
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
        lat  = 0;
        o_ea = '0; o_ld = '0; o_al = 1'b0; o_il = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat  = i;
                o_ea = bus.ea;
                o_ld = bus.ld_data;
                o_al = bus.exc_align;
                o_il = bus.exc_illegal;
                break;
            end
        end
        check_output({tag, ".latency"}, 32'(lat), 32'(x_lat));
        check_output({tag, ".ea"}, o_ea, x_ea);
        check_output({tag, ".ld_data"}, o_ld, x_ld);
        check_output({tag, ".exc_align"}, 32'(o_al), 32'(x_al));
        check_output({tag, ".exc_illegal"}, 32'(o_il), 32'(x_il));
        @(negedge clk);
        check_output({tag, ".done_clear"}, {30'd0, bus.done, bus.exc_align | bus.exc_illegal}, 32'd0);
        bus.dbg_ridx = rt;
        #1 check_output({tag, ".gpr_rt"}, bus.dbg_rdata, (rt == 0) ? 32'd0 : gpr_m[rt]);
    endtask

    initial begin
        int          cnt;
        int          last;
        logic [31:0] x_ea;
        logic [31:0] x_ld;
        logic        x_al;
        logic        x_il;
        int          x_lat;

        total = 0;
        bad   = 0;
        bus.op_valid = 1'b0;
        bus.opcode   = '0;
        bus.rs       = '0;
        bus.rt       = '0;
        bus.imm      = '0;
        bus.dbg_ridx = 5'd5;
        model_reset();

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        $display("[TB] reset state");
        check_output("rst.dbg5", bus.dbg_rdata, 32'd5);
        check_output("rst.op_ready", 32'(bus.op_ready), 32'd1);
        check_output("rst.done", 32'(bus.done), 32'd0);
        check_output("rst.ld_data", bus.ld_data, 32'd0);
        check_output("rst.ea", bus.ea, 32'd0);
        check_output("rst.exc", {30'd0, bus.exc_align, bus.exc_illegal}, 32'd0);

        $display("[TB] directed operations");
        apply_stimulus(6'b100011, 5'd2, 5'd7, 16'd4, "lw_misalign");
        apply_stimulus(6'b100011, 5'd4, 5'd9, 16'hFFFC, "lw_ea0");
        apply_stimulus(6'b101011, 5'd0, 5'd3, 16'd8, "sw_mem2");
        apply_stimulus(6'b100011, 5'd0, 5'd10, 16'd8, "lw_mem2");
        apply_stimulus(6'b100011, 5'd0, 5'd11, 16'd140, "lw_wrap_hi");
        apply_stimulus(6'b100011, 5'd0, 5'd14, 16'hFFFC, "lw_wrap_neg");
        apply_stimulus(6'b100011, 5'd0, 5'd0, 16'd20, "lw_rt0");
        apply_stimulus(6'b100001, 5'd0, 5'd5, 16'd0, "lh");
        apply_stimulus(6'b000000, 5'd1, 5'd6, 16'd0, "illegal0");
        apply_stimulus(6'b101000, 5'd0, 5'd1, 16'd0, "sb");
        apply_stimulus(6'b100000, 5'd0, 5'd15, 16'd0, "lb");
        apply_stimulus(6'b100100, 5'd0, 5'd16, 16'd0, "lbu");

        $display("[TB] op_valid held during busy");
        model_op(6'b100011, 5'd0, 5'd12, 16'd4, x_ea, x_ld, x_al, x_il, x_lat);
        bus.opcode   = 6'b100011;
        bus.rs       = 5'd0;
        bus.rt       = 5'd12;
        bus.imm      = 16'd4;
        bus.op_valid = 1'b1;
        cnt  = 0;
        last = -1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (bus.done) begin
                cnt++;
                check_output("held.ld_data", bus.ld_data, x_ld);
                if (last >= 0) check_output("held.gap", 32'(n - last), 32'd4);
                last = n;
            end
        end
        bus.op_valid = 1'b0;
        check_output("held.count", 32'(cnt), 32'd4);
        @(negedge clk);

        $display("[TB] randomized operations");
        for (int n = 0; n < 40; n++) begin
            apply_stimulus(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 31)),
                           5'($urandom_range(0, 31)), 16'($urandom_range(0, 191) - 64), "rand");
        end

        $display("[TB] reset during store");
        bus.opcode   = 6'b101011;
        bus.rs       = 5'd0;
        bus.rt       = 5'd5;
        bus.imm      = 16'd8;
        bus.op_valid = 1'b1;
        @(posedge clk);
        #1 bus.op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_output("midrst.op_ready", 32'(bus.op_ready), 32'd1);
        check_output("midrst.done", 32'(bus.done), 32'd0);
        check_output("midrst.ea", bus.ea, 32'd0);
        check_output("midrst.ld_data", bus.ld_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.dbg_ridx = 5'd9;
        #1 check_output("midrst.gpr9", bus.dbg_rdata, 32'd9);
        apply_stimulus(6'b100011, 5'd0, 5'd13, 16'd8, "midrst.mem2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
